sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, SRAM cycles held per halfword phase; legal range 1..15.
REQ-002 Parameter: BASE_ADDR, default 1024, byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 wr_en  in  1  store request from the MEM stage.
REQ-006 rd_en  in  1  load request from the MEM stage.
REQ-007 address  in  32  byte address; this is the EXE ALU result.
REQ-008 write_data  in  32  store data; this is the Rm value.
REQ-009 read_data  out  32  load result.
REQ-010 ready  out  1  low freezes the pipeline; high lets the pipeline advance.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  out  18  SRAM halfword address.
REQ-013 SRAM_WE_N  out  1  SRAM write strobe, active-low.

Function
REQ-014 The controller SHALL implement these states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-015 Word index: word = (address - BASE_ADDR)[18:2], computed modulo 2^32; address[1:0] is ignored.
REQ-016 SRAM_ADDR SHALL be {word, 1'b0} in the LO states and {word, 1'b1} in the HI states.
REQ-017 In IDLE, wr_en=1 SHALL move the FSM to WR_LO; otherwise rd_en=1 SHALL move it to RD_LO; if neither is high, the FSM stays in IDLE.
REQ-018 When wr_en and rd_en are both high, the write SHALL take priority and the read SHALL be ignored.
REQ-019 address and write_data SHALL be latched on the edge that leaves IDLE; later changes to these inputs have no effect on the access in progress.
REQ-020 Each LO/HI state SHALL last exactly WAIT_CYCLES cycles, counted by an internal counter that is cleared on every state change.
REQ-021 Transition chains: RD_LO then RD_HI then DONE; WR_LO then WR_HI then DONE; DONE lasts 1 cycle and then returns to IDLE.
REQ-022 Read capture: SRAM_DQ SHALL be sampled into read_data[15:0] on the final RD_LO cycle and into read_data[31:16] on the final RD_HI cycle.
REQ-023 Write drive: SRAM_DQ SHALL carry write_data[15:0] in WR_LO and write_data[31:16] in WR_HI.
REQ-024 SRAM_WE_N SHALL be 0 in every cycle of WR_LO and WR_HI, and 1 in every other cycle.
REQ-025 SRAM_DQ SHALL be high-impedance in every state except WR_LO and WR_HI.
REQ-026 ready (combinational) SHALL be:
  - 1 in IDLE when wr_en=0 and rd_en=0;
  - 0 in IDLE when a request is present;
  - 0 in all LO and HI states;
  - 1 in DONE.
REQ-027 Latency SHALL be 2*WAIT_CYCLES+1 cycles from the request cycle to the DONE cycle; with WAIT_CYCLES=2, ready returns high 5 cycles after the request.
REQ-028 read_data SHALL hold its value from DONE until the next completed read; writes SHALL NOT modify read_data.
REQ-029 A request held high through DONE and into IDLE SHALL start a new access; a request deasserted mid-access SHALL NOT abort it.
REQ-030 SRAM_ADDR SHALL be 0 in IDLE and DONE.

Reset
REQ-031 On rst=1, regardless of clk, the controller SHALL immediately enter this state:
  - state IDLE;
  - counter 0;
  - read_data 0;
  - latched address and data 0;
  - SRAM_WE_N 1;
  - SRAM_DQ high-impedance;
  - SRAM_ADDR 0.
REQ-032 When reset is asserted in the middle of an access, that access SHALL be abandoned with no further SRAM_WE_N pulse, and ready SHALL follow REQ-026 from IDLE.

Verification
REQ-033 Reset idle: rst pulse, no requests -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
REQ-034 Write: wr_en=1, address=1032, write_data=0xDEADBEEF, WAIT=2 -> expected response:
  - SRAM_ADDR=4 with DQ=0xBEEF and WE_N=0 for 2 cycles;
  - then SRAM_ADDR=5 with DQ=0xDEAD for 2 cycles;
  - ready=1 in cycle 5.
REQ-035 Read: SRAM model holds 0x1234 at halfword 4 and 0xABCD at halfword 5; rd_en=1, address=1032 -> read_data=0xABCD1234 in DONE, ready low for exactly cycles 0-4.
REQ-036 Collision and latch: wr_en=rd_en=1, with address changed in cycle 2 -> a write to the cycle-0 address only; read_data unchanged.
REQ-037 Mid-operation reset: assert rst during WR_HI -> WE_N=1 and DQ=Z immediately; state IDLE; the next read completes normally.
REQ-038 Back-to-back: rd_en held high for 12 cycles with WAIT=1 -> consecutive DONE pulses 4 cycles apart, ready low in between.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM.
// Each access is split into a low and a high halfword phase, and each phase
// is held on the bus for WAIT_CYCLES cycles. ready stalls the pipeline
// until the access reaches DONE.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StWrLo,
    StWrHi,
    StDone
  } state_e;

  // Counter value seen in the final cycle of a halfword phase.
  localparam logic [3:0] CntLast = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [16:0] word;
  logic        phase_last;
  logic        start;
  logic        drive;
  logic [15:0] dq_out;

  assign phase_last = (cnt_q == CntLast);
  assign start      = (state_q == StIdle) && (wr_en || rd_en);

  // Word index relative to the SRAM window; wraps modulo 2^32 and drops the
  // byte offset in address[1:0].
  assign word = 17'((addr_q - BASE_ADDR) >> 2);

  // Next-state logic: each halfword phase lasts WAIT_CYCLES cycles, and the
  // counter restarts from zero whenever the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        // A write wins over a simultaneous read.
        if (wr_en) begin
          state_d = StWrLo;
        end else if (rd_en) begin
          state_d = StRdLo;
        end
      end
      StRdLo: begin
        if (phase_last) state_d = StRdHi;
        else            cnt_d   = cnt_q + 4'd1;
      end
      StRdHi: begin
        if (phase_last) state_d = StDone;
        else            cnt_d   = cnt_q + 4'd1;
      end
      StWrLo: begin
        if (phase_last) state_d = StWrHi;
        else            cnt_d   = cnt_q + 4'd1;
      end
      StWrHi: begin
        if (phase_last) state_d = StDone;
        else            cnt_d   = cnt_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM bus and pipeline handshake, decoded from the current state only.
  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    drive     = 1'b0;
    dq_out    = '0;
    unique case (state_q)
      StIdle: ready = !(wr_en || rd_en);
      StRdLo: SRAM_ADDR = {word, 1'b0};
      StRdHi: SRAM_ADDR = {word, 1'b1};
      StWrLo: begin
        SRAM_ADDR = {word, 1'b0};
        SRAM_WE_N = 1'b0;
        drive     = 1'b1;
        dq_out    = wdata_q[15:0];
      end
      StWrHi: begin
        SRAM_ADDR = {word, 1'b1};
        SRAM_WE_N = 1'b0;
        drive     = 1'b1;
        dq_out    = wdata_q[31:16];
      end
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;
  assign read_data = rdata_q;

  // State and phase counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request operands once, so the pipeline may move on to the
  // next address while this access is still in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      addr_q  <= address;
      wdata_q <= write_data;
    end
  end

  // Sample each halfword at the end of its phase, when the SRAM data is
  // settled. Writes never touch the read result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (phase_last && (state_q == StRdLo)) begin
      rdata_q[15:0] <= SRAM_DQ;
    end else if (phase_last && (state_q == StRdHi)) begin
      rdata_q[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomised self-checking bench for sram_controller. An array stands in for
// the SRAM (it always drives the bus while WE_N is high). A separate model
// memory plus access-level timing rules predict every bus cycle.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam int          W1   = 1;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          MemN = 262144;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with WAIT_CYCLES = 2
  logic        wr_en, rd_en, ready, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;

  // DUT with WAIT_CYCLES = 1, used for back-to-back reads
  logic        rd1, ready1, we_n1;
  logic [31:0] address1, read_data1;
  logic [17:0] addr1;
  wire  [15:0] dq1;

  logic [15:0] mem     [0:MemN-1];
  logic [15:0] ref_mem [0:MemN-1];
  logic        mem_init = 1'b0;
  logic [31:0] exp_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] init_pat(input logic [17:0] a);
    return 16'(a) * 16'h9e37 + 16'h5a3c;
  endfunction

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(W1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd1), .address(address1),
    .write_data(32'h0), .read_data(read_data1), .ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1)
  );

  // SRAM stand-ins: output enable tied on, so they drive whenever WE_N is high.
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;
  assign dq1     = we_n1 ? init_pat(addr1) : 16'hzzzz;

  // SRAM storage: filled once, then written mid-cycle while WE_N is low.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MemN; i++) mem[i] <= init_pat(18'(i));
      mem_init <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One access on dut, checked cycle by cycle. The request is dropped after
  // the first cycle and the operands are scrambled from cycle 2 onwards.
  // Expected timing: request cycle, W low-phase cycles, W high-phase cycles,
  // then one DONE cycle.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
    logic [16:0] wd;
    logic [17:0] ha;
    logic [15:0] half;
    logic [35:0] exp_v;
    logic        is_wr, is_rd;
    wd    = 17'((a - BASE) >> 2);
    is_wr = wr;
    is_rd = rd && !wr;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    for (int c = 0; c <= 2 * W + 1; c++) begin
      @(negedge clk);
      if (c == 0 || c == 2 * W + 1) begin
        exp_v = {(c != 0), 1'b1, 18'd0, ref_mem[0]};
      end else begin
        ha    = {wd, (c > W)};
        half  = (c > W) ? d[31:16] : d[15:0];
        exp_v = is_wr ? {1'b0, 1'b0, ha, half} : {1'b0, 1'b1, ha, ref_mem[ha]};
      end
      check($sformatf("%s_c%0d", tag, c), 64'({ready, sram_we_n, sram_addr, sram_dq}),
            64'(exp_v));
      if (c == 2 * W + 1) check({tag, "_rdata"}, 64'(read_data), 64'(exp_rdata));
      @(posedge clk); #1;
      if (c == 0) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      if (c == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
      if (c == 2 * W) begin
        if (is_wr) begin
          ref_mem[{wd, 1'b0}] = d[15:0];
          ref_mem[{wd, 1'b1}] = d[31:16];
        end
        if (is_rd) exp_rdata = {ref_mem[{wd, 1'b1}], ref_mem[{wd, 1'b0}]};
      end
    end
  endtask

  task automatic idle_cycle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    check("idle", 64'({ready, sram_we_n, sram_addr, sram_dq}),
          64'({1'b1, 1'b1, 18'd0, ref_mem[0]}));
    @(posedge clk); #1;
  endtask

  initial begin
    int          op;
    logic [31:0] a;
    int          per;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    rd1 = 1'b0; address1 = '0; exp_rdata = '0;
    for (int i = 0; i < MemN; i++) ref_mem[i] = init_pat(18'(i));

    // Reset, no requests
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 64'({ready, sram_we_n, sram_addr, sram_dq}),
          64'({1'b1, 1'b1, 18'd0, ref_mem[0]}));
    check("rst_rdata", 64'(read_data), 64'(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    // Directed write/read of word 2 (halfwords 4 and 5)
    run_access(1'b1, 1'b0, 32'd1032, 32'hdeadbeef, "wr_dead");
    run_access(1'b1, 1'b0, 32'd1032, 32'habcd1234, "wr_abcd");
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, "rd_abcd");
    check("rd_abcd_val", 64'(read_data), 64'(32'habcd1234));

    // Write and read together: only the write happens, read_data kept
    run_access(1'b1, 1'b1, 32'd1037, 32'h0badf00d, "coll");
    check("coll_keep", 64'(read_data), 64'(32'habcd1234));
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, "coll_rd");
    check("coll_val", 64'(read_data), 64'(32'h0badf00d));

    // Random traffic, occasionally far outside the window
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      case (op)
        0:       run_access(1'b0, 1'b1, a, $urandom, "rnd_rd");
        1:       run_access(1'b1, 1'b0, a, $urandom, "rnd_wr");
        2:       run_access(1'b1, 1'b1, a, $urandom, "rnd_both");
        default: idle_cycle();
      endcase
    end

    // Reset arriving just after the write enters its high phase (word 10)
    wr_en = 1'b1; address = BASE + 32'd40; write_data = 32'h1111_2222;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_hi", 64'({sram_we_n, sram_addr}), 64'({1'b0, 18'd21}));
    rst = 1'b1;
    #1;
    ref_mem[20] = 16'h2222;
    exp_rdata   = '0;
    check("mid_rst", 64'({ready, sram_we_n, sram_addr, sram_dq}),
          64'({1'b1, 1'b1, 18'd0, ref_mem[0]}));
    check("mid_rdata", 64'(read_data), 64'(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    run_access(1'b0, 1'b1, BASE + 32'd40, 32'h0, "rd_after_rst");

    // Back-to-back reads on the WAIT_CYCLES = 1 instance (word 3)
    per = 2 * W1 + 2;
    rd1 = 1'b1; address1 = BASE + 32'd12;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", c), 64'(ready1),
            64'((c % per == per - 1) || (c == 12)));
      if (c % per == per - 1) begin
        check($sformatf("b2b_rdata_c%0d", c), 64'(read_data1),
              64'({init_pat(18'd7), init_pat(18'd6)}));
      end
      @(posedge clk); #1;
      if (c == 11) rd1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
